// File: rtl/board_io_bridge.sv
// board_io_bridge: board pins <-> single-cycle core I/O ports.
// Switch/key synchronise + debounce, stretched core reset, run/step
// clock-enable FSM, registered LED/HEX outputs with PC-debug display.
// Optional hardware breakpoint: define BOARD_IO_BRKPT_EN.

// One debounced bit: two-flop synchroniser followed by a stable-count filter.
module board_io_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  // Flip on the DEBOUNCE_CYC-th consecutive differing cycle, so the
  // raw-to-clean latency is exactly DEBOUNCE_CYC+2 including the synchroniser.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          meta_q, sync_q, clean_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then count consecutive cycles where sync differs from clean.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q <= i_raw;
      sync_q <= meta_q;
      if (sync_q == clean_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_clean = clean_q;
endmodule

module board_io_bridge #(
  parameter int NUM_SW       = 18,
  parameter int NUM_HEX      = 8,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RST_HOLD     = 16,
  parameter int RST_SW_IDX   = NUM_SW - 1,
  parameter int MODE_SW_IDX  = NUM_SW - 2,
  parameter int DISP_SW_IDX  = NUM_SW - 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_SW-1:0]    i_sw,
  input  logic                 i_key_step,
  output logic [31:0]          o_io_sw,
  output logic                 o_core_reset,
  output logic                 o_core_en,
  output logic [15:0]          o_step_cnt,
  input  logic [31:0]          i_io_ledr,
  input  logic [31:0]          i_io_ledg,
  input  logic [7*NUM_HEX-1:0] i_io_hex,
  input  logic [31:0]          i_pc_debug,
  input  logic                 i_insn_vld,
`ifdef BOARD_IO_BRKPT_EN
  input  logic [31:0]          i_brk_addr,
  input  logic                 i_brk_vld,
`endif
  output logic [NUM_SW-1:0]    o_ledr,
  output logic [7:0]           o_ledg,
  output logic [7*NUM_HEX-1:0] o_hex
);
  localparam int HW = $clog2(RST_HOLD + 1);

`ifdef BOARD_IO_BRKPT_EN
  typedef enum logic [2:0] {S_HOLD, S_RUN, S_STEP_WAIT, S_STEP_PULSE, S_BRK} state_t;
`else
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_STEP_WAIT, S_STEP_PULSE} state_t;
`endif

  // ---- input conditioning: switches plus step key as the top bit ----
  logic [NUM_SW:0] raw, clean;
  assign raw = {i_key_step, i_sw};

  for (genvar b = 0; b <= NUM_SW; b++) begin : g_db
    board_io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_raw   (raw[b]),
      .o_clean (clean[b])
    );
  end

  logic mode, disp, key_clean;
  assign mode      = clean[MODE_SW_IDX];
  assign disp      = clean[DISP_SW_IDX];
  assign key_clean = clean[NUM_SW];

  // Control bits are deliberately left visible to the core.
  assign o_io_sw = 32'(clean[NUM_SW-1:0]);

  // ---- reset stretcher ----
  logic          rst_src;
  logic [HW-1:0] hold_q, hold_d;
  assign rst_src = i_reset | clean[RST_SW_IDX];

  always_comb begin
    hold_d = hold_q;
    if (rst_src)              hold_d = HW'(RST_HOLD);
    else if (hold_q != '0)    hold_d = hold_q - 1'b1;
  end

  // Hold counter reloads while the source is up, counts down after it falls.
  always_ff @(posedge i_clk) begin
    if (i_reset) hold_q <= HW'(RST_HOLD);
    else         hold_q <= hold_d;
  end

  assign o_core_reset = rst_src | (hold_q != '0);

  // ---- run / step enable FSM ----
  state_t state_q;
  logic   key_prev_q;
  logic   key_rise;
  logic   run_st;
  assign key_rise = key_clean & ~key_prev_q;
  assign run_st   = (state_q == S_RUN) || (state_q == S_STEP_PULSE);

`ifdef BOARD_IO_BRKPT_EN
  logic brk_hit, brk_armed_q;
  // Break is taken in the matching cycle itself, so the enable drops at once.
  assign brk_hit   = (state_q == S_RUN) && i_brk_vld && (i_pc_debug == i_brk_addr);
  assign o_core_en = run_st && !o_core_reset && !brk_hit;
`else
  assign o_core_en = run_st && !o_core_reset;
`endif

  // Enable sequencing; core reset always parks the FSM in HOLD.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_HOLD;
      key_prev_q <= 1'b0;
`ifdef BOARD_IO_BRKPT_EN
      brk_armed_q <= 1'b0;
`endif
    end else begin
      key_prev_q <= key_clean;
`ifdef BOARD_IO_BRKPT_EN
      // Remembers the mode=1 half of the 0->1->0 toggle that resumes from BRK.
      brk_armed_q <= (state_q == S_BRK) && (brk_armed_q || mode);
`endif
      if (o_core_reset) begin
        state_q <= S_HOLD;
      end else begin
        case (state_q)
          S_HOLD:       state_q <= mode ? S_STEP_WAIT : S_RUN;
          S_RUN: begin
`ifdef BOARD_IO_BRKPT_EN
            if (brk_hit)   state_q <= S_BRK;
            else
`endif
            if (mode)      state_q <= S_STEP_WAIT;
          end
          S_STEP_WAIT: begin
            if (!mode)         state_q <= S_RUN;
            else if (key_rise) state_q <= S_STEP_PULSE;
          end
          S_STEP_PULSE: state_q <= mode ? S_STEP_WAIT : S_RUN;
`ifdef BOARD_IO_BRKPT_EN
          S_BRK: begin
            if (key_rise)                  state_q <= S_STEP_PULSE;
            else if (brk_armed_q && !mode) state_q <= S_RUN;
          end
`endif
          default:      state_q <= S_HOLD;
        endcase
      end
    end
  end

  // Enabled-cycle counter, held at zero while the core is in reset.
  logic [15:0] step_cnt_q;
  always_ff @(posedge i_clk) begin
    if (i_reset || o_core_reset) step_cnt_q <= '0;
    else if (o_core_en)          step_cnt_q <= step_cnt_q + 16'd1;
  end
  assign o_step_cnt = step_cnt_q;

  // ---- display path ----
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [7*NUM_HEX-1:0] hex_d, hex_q;
  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    assign hex_d[7*k +: 7] = disp ? seg7(i_pc_debug[4*k +: 4]) : i_io_hex[7*k +: 7];
  end

  logic [NUM_SW-1:0] ledr_q;
  logic [7:0]        ledg_q;

  // Board outputs registered once; hex blanks in reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= {NUM_HEX{7'h7F}};
    end else begin
      ledr_q <= i_io_ledr[NUM_SW-1:0];
      ledg_q <= {i_io_ledg[7:1], i_insn_vld};
      hex_q  <= hex_d;
    end
  end

  assign o_ledr = ledr_q;
  assign o_hex  = hex_q;
`ifdef BOARD_IO_BRKPT_EN
  assign o_ledg = {ledg_q[7] | (state_q == S_BRK), ledg_q[6:0]};
`else
  assign o_ledg = ledg_q;
`endif

  // Only slices of these words reach the board.
  logic unused_in;
  assign unused_in = ^{i_io_ledr, i_io_ledg, i_pc_debug};
endmodule

// File: tb/tb_board_io_bridge.sv
// Bench for board_io_bridge with short debounce/reset-hold parameters.
module tb_board_io_bridge;
  localparam int NSW = 18;
  localparam int NHX = 8;
  localparam int DB  = 4;
  localparam int RH  = 3;
  localparam int RST_I = NSW - 1, MODE_I = NSW - 2, DISP_I = NSW - 3;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [NSW-1:0]   i_sw;
  logic             i_key_step;
  logic [31:0]      o_io_sw;
  logic             o_core_reset, o_core_en;
  logic [15:0]      o_step_cnt;
  logic [31:0]      i_io_ledr, i_io_ledg, i_pc_debug;
  logic [7*NHX-1:0] i_io_hex;
  logic             i_insn_vld;
  logic [NSW-1:0]   o_ledr;
  logic [7:0]       o_ledg;
  logic [7*NHX-1:0] o_hex;
`ifdef BOARD_IO_BRKPT_EN
  logic [31:0]      i_brk_addr;
  logic             i_brk_vld;
`endif

  board_io_bridge #(.NUM_SW(NSW), .NUM_HEX(NHX), .DEBOUNCE_CYC(DB), .RST_HOLD(RH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sw(i_sw), .i_key_step(i_key_step),
    .o_io_sw(o_io_sw), .o_core_reset(o_core_reset), .o_core_en(o_core_en),
    .o_step_cnt(o_step_cnt), .i_io_ledr(i_io_ledr), .i_io_ledg(i_io_ledg),
    .i_io_hex(i_io_hex), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
`ifdef BOARD_IO_BRKPT_EN
    .i_brk_addr(i_brk_addr), .i_brk_vld(i_brk_vld),
`endif
    .o_ledr(o_ledr), .o_ledg(o_ledg), .o_hex(o_hex));

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Active-low gfedcba glyphs for 0..F.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic        disp;
    logic [31:0] pc;
    logic [55:0] hx;
    logic [31:0] ledr;
    logic [31:0] ledg;
    logic        insn;
    logic [55:0] e_hex;
    logic [17:0] e_ledr;
    logic [7:0]  e_ledg;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_clean(input int idx, input logic v, input string nm, output int n);
    n = 0;
    while (o_io_sw[idx] !== v && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (o_io_sw[idx] !== v) begin
      n_fail++;
      $display("FAIL %s: clean switch %0d got %0b expected %0b (timeout)", nm, idx, o_io_sw[idx], v);
    end
  endtask

  task automatic set_disp(input logic d);
    if (i_sw[DISP_I] !== d) begin
      i_sw[DISP_I] = d;
      repeat (DB + 4) tick();
    end
  endtask

  // Display reference: digit k shows PC nibble k when in PC mode.
  function automatic logic [55:0] exp_hex(input logic d, input logic [31:0] pc, input logic [55:0] hx);
    logic [55:0] r;
    r = hx;
    if (d) for (int k = 0; k < NHX; k++) r[7*k +: 7] = glyph[pc[4*k +: 4]];
    return r;
  endfunction

  int pulses, run_len, max_run;
  task automatic sample_en();
    tick();
    if (o_core_en) begin
      run_len++;
      if (run_len == 1) pulses++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit hist[$];
    bit clean0;
    logic [55:0] hx;

    tbl[0] = '{1'b1, 32'h0000_1A3C, 56'h0, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h30, 7'h46}, 18'h3FFFF, 8'hFE};
    tbl[1] = '{1'b1, 32'hFEDC_BA98, 56'h0, 32'h0001_2345, 32'h0000_0000, 1'b1,
               {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 18'h12345, 8'h01};
    tbl[2] = '{1'b1, 32'h7654_3210, 56'h0, 32'hFFFC_0000, 32'h0000_00AA, 1'b1,
               {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 18'h00000, 8'hAB};
    tbl[3] = '{1'b0, 32'h0000_1A3C, 56'h01_2345_6789_ABCD, 32'h0000_0155, 32'h0000_0080, 1'b0,
               56'h01_2345_6789_ABCD, 18'h00155, 8'h80};
    tbl[4] = '{1'b0, 32'h0000_0000, 56'hFF_FFFF_FFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1,
               56'hFF_FFFF_FFFF_FFFF, 18'h00000, 8'hFF};

    i_reset = 1'b1; i_sw = '0; i_key_step = 1'b0;
    i_io_ledr = '0; i_io_ledg = '0; i_io_hex = '0; i_pc_debug = '0; i_insn_vld = 1'b0;
`ifdef BOARD_IO_BRKPT_EN
    i_brk_addr = '0; i_brk_vld = 1'b0;
`endif
    i_io_ledr = 32'hFFFF_FFFF; i_io_ledg = 32'hFF; i_insn_vld = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_core_reset", o_core_reset, 1);
    chk("rst_core_en", o_core_en, 0);
    chk("rst_step_cnt", o_step_cnt, 0);
    chk("rst_ledr", o_ledr, 0);
    chk("rst_ledg", o_ledg, 0);
    chk("rst_hex_blank", o_hex, {NHX{7'h7F}});
    chk("rst_io_sw", o_io_sw, 0);

    // Reset release in run mode: stretched reset, then RUN, then counting
    i_io_ledr = '0; i_io_ledg = '0; i_insn_vld = 1'b0;
    i_reset = 1'b0;
    #1 chk("rel_rst_c0", o_core_reset, 1);
    tick(); chk("rel_rst_c1", o_core_reset, 1);
    tick(); chk("rel_rst_c2", o_core_reset, 1);
    tick(); chk("rel_rst_c3", o_core_reset, 0);
    chk("rel_en_hold", o_core_en, 0);
    tick(); chk("rel_en_run", o_core_en, 1);
    chk("rel_cnt0", o_step_cnt, 0);
    repeat (5) tick();
    chk("rel_cnt5", o_step_cnt, 5);

    // Short glitch must not propagate; held level appears DB+2 cycles later
    i_sw[0] = 1'b1;
    repeat (3) tick();
    i_sw[0] = 1'b0;
    n = 0;
    repeat (10) begin tick(); if (o_io_sw[0]) n++; end
    chk("glitch_blocked", n, 0);
    i_sw[0] = 1'b1;
    for (int i = 1; i <= DB + 2; i++) begin
      tick();
      chk($sformatf("db_edge_c%0d", i), o_io_sw[0], (i >= DB + 2));
    end
    i_sw[0] = 1'b0;
    repeat (DB + 6) tick();

    // Random switch chatter vs. window model: clean flips once the raw value
    // seen DB+1..2 edges back has differed from clean for DB straight samples.
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
    clean0 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) i_sw[0] = ~i_sw[0];
      tick();
      hist.push_back(i_sw[0]);
      begin
        bit all_diff;
        int last;
        all_diff = 1'b1;
        last = hist.size() - 1;
        for (int j = last - DB - 1; j <= last - 2; j++)
          if (hist[j] == clean0) all_diff = 1'b0;
        if (all_diff) clean0 = ~clean0;
      end
      chk("rand_debounce", o_io_sw[0], clean0);
    end
    i_sw[0] = 1'b0;
    repeat (DB + 6) tick();

    // Table-driven display/LED vectors
    for (int t = 0; t < 5; t++) begin
      set_disp(tbl[t].disp);
      i_pc_debug = tbl[t].pc; i_io_hex = tbl[t].hx; i_io_ledr = tbl[t].ledr;
      i_io_ledg = tbl[t].ledg; i_insn_vld = tbl[t].insn;
      tick();
      chk($sformatf("tbl%0d_hex", t), o_hex, tbl[t].e_hex);
      chk($sformatf("tbl%0d_ledr", t), o_ledr, tbl[t].e_ledr);
      chk($sformatf("tbl%0d_ledg", t), o_ledg, tbl[t].e_ledg);
    end
    chk("io_sw_disp_zext", o_io_sw, 32'h0);

    // Random display/LED traffic in both display modes
    for (int p = 0; p < 2; p++) begin
      set_disp(p[0]);
      chk("io_sw_unmasked", o_io_sw, {14'b0, i_sw});
      for (int r = 0; r < 20; r++) begin
        i_pc_debug = $urandom; i_io_ledr = $urandom; i_io_ledg = $urandom;
        i_insn_vld = 1'($urandom_range(0, 1));
        hx = {$urandom, $urandom};
        i_io_hex = hx;
        tick();
        chk("rand_hex", o_hex, exp_hex(p[0], i_pc_debug, hx));
        chk("rand_ledr", o_ledr, i_io_ledr[NSW-1:0]);
        chk("rand_ledg", o_ledg, {i_io_ledg[7:1], i_insn_vld});
      end
    end
    set_disp(1'b0);
    i_io_ledg = '0;

`ifdef BOARD_IO_BRKPT_EN
    // Breakpoint in run mode, then a single step past it
    i_brk_addr = 32'h10; i_brk_vld = 1'b1;
    i_pc_debug = 32'h08; tick(); chk("brk_pc08_en", o_core_en, 1);
    i_pc_debug = 32'h0C; tick(); chk("brk_pc0c_en", o_core_en, 1);
    i_pc_debug = 32'h10; #1 chk("brk_hit_en", o_core_en, 0);
    tick(); chk("brk_hold_en", o_core_en, 0);
    chk("brk_ledg7", o_ledg[7], 1);
    i_key_step = 1'b1;
    n = 0;
    while (!o_core_en && n < 40) begin tick(); n++; end
    chk("brk_step_pulse", o_core_en, 1);
    i_pc_debug = 32'h14;
    tick(); chk("brk_resume_en", o_core_en, 1);
    i_key_step = 1'b0; i_brk_vld = 1'b0;
    repeat (DB + 6) tick();
`endif

    // Reset switch raised mid-run: HOLD, enable off, counter cleared
    i_sw[RST_I] = 1'b1;
    wait_clean(RST_I, 1'b1, "rst_sw_rise", n);
    chk("rst_sw_latency", n, DB + 2);
    chk("rst_sw_core_reset", o_core_reset, 1);
    chk("rst_sw_en", o_core_en, 0);
    tick(); chk("rst_sw_cnt", o_step_cnt, 0);
    i_sw[RST_I] = 1'b0;
    wait_clean(RST_I, 1'b0, "rst_sw_fall", n);
    k = 0;
    while (o_core_reset && k < 40) begin k++; tick(); end
    chk("rst_sw_hold_len", k, RH);
    chk("rst_sw_en_release", o_core_en, 0);
    tick(); chk("rst_sw_run_resume", o_core_en, 1);
    repeat (4) tick(); chk("rst_sw_cnt_resume", o_step_cnt, 4);

    // Enter step mode through a reset so the counter starts from zero
    i_sw[RST_I] = 1'b1;
    wait_clean(RST_I, 1'b1, "step_rst_rise", n);
    i_sw[MODE_I] = 1'b1;
    repeat (DB + 6) tick();
    i_sw[RST_I] = 1'b0;
    wait_clean(RST_I, 1'b0, "step_rst_fall", n);
    repeat (10) tick();
    chk("step_wait_en", o_core_en, 0);
    chk("step_wait_cnt", o_step_cnt, 0);
    chk("step_io_sw", o_io_sw, {14'b0, i_sw});

    // Three long key presses -> three one-cycle pulses
    pulses = 0; run_len = 0; max_run = 0;
    for (int p = 0; p < 3; p++) begin
      i_key_step = 1'b1;
      repeat (20) sample_en();
      i_key_step = 1'b0;
      repeat (20) sample_en();
    end
    chk("step_pulses", pulses, 3);
    chk("step_pulse_width", max_run, 1);
    chk("step_cnt3", o_step_cnt, 3);

    // Back to run mode
    i_sw[MODE_I] = 1'b0;
    wait_clean(MODE_I, 1'b0, "mode_fall", n);
    tick(); chk("mode_run_en", o_core_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/board_io_bridge.md
Name: board_io_bridge

Overview:
- Parametrised board-side I/O bridge between the board pins (switches, step key, LEDs, 7-segment displays) and the single-cycle core's I/O ports.
- Generalises the plain pin mapping with:
  - switch synchronisation and debouncing;
  - a stretched core reset;
  - run/single-step clock-enable control;
  - registered LED/HEX outputs with a selectable PC-debug display mode.
- Sits at top level, between the board pins and the core instance.

Parameters:
- NUM_SW, 18: number of raw switches (3..32).
- NUM_HEX, 8: number of 7-segment digits (1..8).
- DEBOUNCE_CYC, 500000: consecutive stable cycles required before a clean bit changes (>=1).
- RST_HOLD, 16: core reset stretch, in cycles after the reset source releases (>=1).
- RST_SW_IDX, NUM_SW-1: switch bit used as the user reset.
- MODE_SW_IDX, NUM_SW-2: switch bit selecting mode; 1 = step, 0 = run.
- DISP_SW_IDX, NUM_SW-3: switch bit selecting display source; 1 = PC, 0 = core.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_sw  in  NUM_SW  raw asynchronous switches.
- i_key_step  in  1  raw step button, active-high.
- o_io_sw  out  32  debounced switches, zero-extended, to the core.
- o_core_reset  out  1  synchronous reset to the core.
- o_core_en  out  1  core clock enable.
- o_step_cnt  out  16  count of cycles with o_core_en=1.
- i_io_ledr  in  32  core red LED word.
- i_io_ledg  in  32  core green LED word.
- i_io_hex  in  7*NUM_HEX  core segment data; digit k is at bits [7k+6:7k].
- i_pc_debug  in  32  core PC.
- i_insn_vld  in  1  core instruction-valid.
- o_ledr  out  NUM_SW  red LEDs.
- o_ledg  out  8  green LEDs.
- o_hex  out  7*NUM_HEX  segments, active-low.

Behaviour:
- Clock and reset:
  - One clock domain, i_clk. All state registers on the rising edge.
  - i_reset is synchronous, active-high and overrides everything.
- Synchroniser: two flops on every i_sw bit and on i_key_step; reset value 0.
- Debounce (per bit):
  - Counter width is $clog2(DEBOUNCE_CYC+1).
  - The counter increments while the synchronised value differs from the clean value, and clears when they are equal.
  - When the count reaches DEBOUNCE_CYC, the clean bit flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never propagates.
  - Latency from raw edge to clean edge is exactly DEBOUNCE_CYC+2 cycles.
  - Clean values reset to 0.
- o_io_sw: {zero, clean_sw}. Control bits are passed through unmasked.
- Reset sequencer:
  - Source = i_reset | clean_sw[RST_SW_IDX].
  - While the source is 1: o_core_reset=1 and the hold counter loads RST_HOLD.
  - After the source falls, o_core_reset stays 1 for exactly RST_HOLD further cycles, then drops.
  - The source reasserting mid-count reloads the counter.
- Enable FSM states: HOLD, RUN, STEP_WAIT, STEP_PULSE.
  - i_reset -> HOLD.
  - Any cycle with o_core_reset=1 -> HOLD, with o_core_en=0.
  - HOLD leaves when o_core_reset=0: to RUN if mode=0, to STEP_WAIT if mode=1.
  - RUN: o_core_en=1; goes to STEP_WAIT when mode becomes 1.
  - STEP_WAIT: o_core_en=0.
    - Rising edge of the clean step key -> STEP_PULSE.
    - mode=0 -> RUN. If a step edge and mode=0 coincide, RUN wins.
  - STEP_PULSE: o_core_en=1 for exactly one cycle, then STEP_WAIT (or RUN if mode=0).
  - A held key yields exactly one pulse.
- o_step_cnt:
  - Increments on every cycle with o_core_en=1, wrapping 0xFFFF->0.
  - Cleared while o_core_reset=1.
- Output registers: one cycle of latency from the inputs.
  - o_ledr = i_io_ledr[NUM_SW-1:0].
  - o_ledg = {i_io_ledg[7:1], i_insn_vld}.
  - o_hex digit k:
    - disp=0: i_io_hex digit k.
    - disp=1: hex-to-7seg encoding of i_pc_debug[4k+3:4k], active-low, gfedcba order. Glyphs: 0=7'h40, 1=7'h79, ..., A=7'h08, F=7'h0E.
- Output reset values: o_ledr=0, o_ledg=0, every hex digit = 7'h7F (blank), o_core_reset=1, o_core_en=0, o_step_cnt=0.

Optional Feature:
- Macro: BOARD_IO_BRKPT_EN.
- Defined:
  - Adds input i_brk_addr (32) and input i_brk_vld (1), and FSM state BRK.
  - In RUN, when i_brk_vld=1 and i_pc_debug==i_brk_addr: the FSM enters BRK in the same cycle, with o_core_en=0 combinationally from that cycle.
  - BRK is left by a step-key edge (-> STEP_PULSE, one instruction) or by a mode 0->1->0 toggle (-> RUN).
  - In BRK, o_ledg[7] is forced to 1.
- Undefined: no ports, no BRK state, o_ledg[7] follows the core.

Test Plan:
1. DEBOUNCE_CYC=4: pulse raw i_sw[0]=1 for 3 cycles -> o_io_sw[0] stays 0. Hold it at 1 -> o_io_sw[0]=1 exactly 6 cycles after the raw edge.
2. RST_HOLD=3: release i_reset with mode=0 -> o_core_reset=1 for 3 cycles after release, then 0. o_core_en=1 on the next cycle; o_step_cnt=5 after 5 enabled cycles.
3. Step mode with step key held for 20 cycles, 3 times -> exactly 3 single-cycle o_core_en pulses, o_step_cnt=3.
4. disp=1, i_pc_debug=0x0000_1A3C -> after one cycle, o_hex digits 0..3 = 7'h46, 7'h30, 7'h08, 7'h79 and digits 4..7 = 7'h40. disp=0 -> o_hex mirrors i_io_hex.
5. Run with the reset switch raised mid-operation -> the FSM enters HOLD, o_core_en=0, o_step_cnt=0; on release, RUN resumes after RST_HOLD cycles.
6. BOARD_IO_BRKPT_EN: i_brk_addr=0x10, i_brk_vld=1, PC sequence 0x08, 0x0C, 0x10 -> o_core_en=0 in the PC=0x10 cycle and o_ledg[7]=1. A step edge then gives one pulse and PC advances to 0x14.
